// File: rtl/morse_keyer.sv
// Morse keyer: turns one character (1..5 dits/dashes) or a word space
// into a timed key line, counting externally supplied time-unit ticks.
module morse_keyer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       char_valid,
    input  logic       space,
    input  logic [2:0] len,
    input  logic [4:0] bits,
    input  logic       abort,
    output logic       key,
    output logic       ready,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [2:0] remain;
    logic [4:0] pat;
    logic       legal;
    logic       mark_last;

    // pat is left-aligned so the symbol on air is always pat[4]
    assign legal     = (len >= 3'd1) && (len <= 3'd5);
    assign mark_last = (cnt == (pat[4] ? 3'd2 : 3'd0));
    assign ready     = (state == IDLE);

    // Sequencer: request accept, symbol timing, gaps and abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            key    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= 3'd0;
            remain <= 3'd0;
            pat    <= 5'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                key   <= 1'b0;
                cnt   <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (char_valid && !abort) begin
                            if (space) begin
                                state <= WORD_GAP;
                                key   <= 1'b0;
                                cnt   <= 3'd0;
                            end else if (legal) begin
                                pat    <= bits << (3'd5 - len);
                                remain <= len;
                                key    <= 1'b1;
                                state  <= MARK;
                                cnt    <= 3'd0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    MARK: begin
                        if (tick) begin
                            if (mark_last) begin
                                key <= 1'b0;
                                cnt <= 3'd0;
                                if (remain > 3'd1) begin
                                    state  <= GAP;
                                    remain <= remain - 3'd1;
                                    pat    <= pat << 1;
                                end else begin
                                    state <= CHAR_GAP;
                                end
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            key   <= 1'b1;
                            state <= MARK;
                            cnt   <= 3'd0;
                        end
                    end
                    CHAR_GAP: begin
                        if (tick) begin
                            if (cnt == 3'd2) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                cnt   <= 3'd0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    WORD_GAP: begin
                        if (tick) begin
                            if (cnt == 3'd6) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                cnt   <= 3'd0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        key   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboarded bench for morse_keyer: requests push an expected key
// waveform (segments of level and tick count); a monitor rebuilds it.
module tb_morse_keyer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       char_valid = 1'b0;
    logic       space = 1'b0;
    logic [2:0] len = 3'd0;
    logic [4:0] bits = 5'd0;
    logic       abort = 1'b0;
    logic       key;
    logic       ready;
    logic       done;
    logic       err;

    int    checks = 0;
    int    errors = 0;
    string expq[$];
    bit    tick_en = 1'b1;
    int    tick_per = 4;
    int    cyc = 0;

    morse_keyer dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .char_valid(char_valid),
        .space(space),
        .len(len),
        .bits(bits),
        .abort(abort),
        .key(key),
        .ready(ready),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Tick source: periodic or random, can be stalled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!tick_en)
                tick = 1'b0;
            else if (tick_per > 0)
                tick = (cyc % tick_per == 0);
            else
                tick = ($urandom_range(0, 2) == 0);
        end
    end

    // Reference: expected waveform from the symbol rules
    function automatic string model(bit sp, bit [2:0] l, bit [4:0] b);
        string s;
        s = "";
        if (sp)
            return "L7";
        if (l == 3'd0 || l > 3'd5)
            return "ERR";
        for (int i = int'(l) - 1; i >= 0; i--) begin
            if (b[i])
                s = {s, "H3"};
            else
                s = {s, "H1"};
            if (i == 0)
                s = {s, "L3"};
            else
                s = {s, "L1"};
        end
        return s;
    endfunction

    function automatic string seg(bit lvl, int n);
        if (lvl)
            return $sformatf("H%0d", n);
        return $sformatf("L%0d", n);
    endfunction

    function automatic void emit(string obs);
        string e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL seq unexpected got %s", obs);
        end else begin
            e = expq.pop_front();
            if (e != obs) begin
                errors++;
                $display("FAIL seq got %s exp %s", obs, e);
            end
        end
    endfunction

    task automatic chk1(string name, logic got, logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    // Monitor: rebuilds level/tick segments of each transmission
    initial begin
        bit    busy;
        bit    lvl;
        int    n;
        string obs;
        busy = 1'b0;
        lvl = 1'b0;
        n = 0;
        obs = "";
        forever begin
            @(negedge clk);
            if (reset) begin
                if (busy)
                    emit("RESET");
                busy = 1'b0;
            end else if (!ready) begin
                if (!busy) begin
                    busy = 1'b1;
                    lvl = key;
                    n = 0;
                    obs = "";
                end else if (key != lvl) begin
                    obs = {obs, seg(lvl, n)};
                    lvl = key;
                    n = 0;
                end
                if (err)
                    emit("ERR_BUSY");
                if (tick)
                    n++;
            end else begin
                if (busy) begin
                    if (done)
                        emit({obs, seg(lvl, n)});
                    else
                        emit($sformatf("ABORT k%0d", key));
                    busy = 1'b0;
                end else if (done) begin
                    emit("SPURIOUS_DONE");
                end
                if (err)
                    emit("ERR");
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready)
            chk1("ready_timeout", ready, 1'b1);
    endtask

    task automatic send(bit sp, bit [2:0] l, bit [4:0] b, bit hold,
                        string exp);
        wait_ready();
        if (!ready)
            return;
        space = sp;
        len = l;
        bits = b;
        char_valid = 1'b1;
        expq.push_back(exp);
        @(posedge clk);
        #1;
        if (!hold)
            char_valid = 1'b0;
        space = 1'($urandom);
        len = 3'($urandom);
        bits = 5'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done)
            chk1("done_timeout", done, 1'b1);
    endtask

    initial begin
        bit          sp;
        bit [2:0]    l;
        bit [4:0]    b;
        bit          legal;
        bit          hold;
        int          rises;
        bit          prev;
        logic        kk;
        int          n;

        repeat (3) @(negedge clk);
        chk1("rst_key", key, 1'b0);
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        #2 reset = 1'b0;

        // letter A with a tick every 4 clocks
        send(0, 3'd2, 5'b00001, 0, model(0, 3'd2, 5'b00001));
        // word space, len ignored
        send(1, 3'd0, 5'b00000, 0, model(1, 3'd0, 5'b00000));
        // illegal length
        send(0, 3'd0, 5'b00000, 0, model(0, 3'd0, 5'b00000));
        chk1("ill_ready", ready, 1'b1);
        chk1("ill_key", key, 1'b0);

        // back-to-back E, char_valid held through the first one
        send(0, 3'd1, 5'b00000, 1, "H1L3");
        wait_done();
        chk1("b2b_ready_in_done", ready, 1'b1);
        space = 1'b0;
        len = 3'd1;
        bits = 5'b00000;
        expq.push_back(model(0, 3'd1, 5'b00000));
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        chk1("b2b_accepted", ready, 1'b0);
        chk1("b2b_key", key, 1'b1);

        tick_per = 0;

        // abort in the second mark of digit 0
        send(0, 3'd5, 5'b11111, 0, "ABORT k0");
        rises = 0;
        prev = 1'b0;
        n = 0;
        while (rises < 2 && n < 3000) begin
            @(negedge clk);
            if (key && !prev)
                rises++;
            prev = key;
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk1("abort_key", key, 1'b0);
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_done", done, 1'b0);

        // abort in idle blocks a request
        wait_ready();
        space = 1'b0;
        len = 3'd1;
        bits = 5'b00000;
        char_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        abort = 1'b0;
        chk1("idle_abort_ready", ready, 1'b1);
        chk1("idle_abort_key", key, 1'b0);
        chk1("idle_abort_err", err, 1'b0);

        // tick stall holds state and key
        send(0, 3'd2, 5'b00010, 0, model(0, 3'd2, 5'b00010));
        @(negedge clk);
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        kk = key;
        repeat (40) @(negedge clk);
        chk1("stall_key", key, kk);
        chk1("stall_busy", ready, 1'b0);
        tick_en = 1'b1;

        // async reset mid-mark
        send(0, 3'd3, 5'b01010, 0, "RESET");
        n = 0;
        @(negedge clk);
        while (!key && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2 reset = 1'b1;
        #1;
        chk1("async_key", key, 1'b0);
        chk1("async_ready", ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        send(0, 3'd3, 5'b01010, 0, model(0, 3'd3, 5'b01010));

        // random traffic
        for (int i = 0; i < 30; i++) begin
            sp = ($urandom_range(0, 5) == 0);
            l = 3'($urandom_range(0, 7));
            b = 5'($urandom);
            legal = sp || (l >= 3'd1 && l <= 3'd5);
            hold = legal && (i < 29) && ($urandom_range(0, 1) == 1);
            send(sp, l, b, hold, model(sp, l, b));
        end
        char_valid = 1'b0;

        n = 0;
        while (expq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_empty got %0d exp 0", expq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
